// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests feeding an IF/ID
// register backed by a one-entry skid buffer for stall/response collisions.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_insn,
  output logic [4:0]  ifid_opcode
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  logic [1:0]   state;
  logic [31:0]  pc;
  logic         squash;
  fetch_entry_t skid;

  assign imem_req    = (state == ISSUE);
  assign imem_addr   = pc;
  assign ifid_opcode = ifid_insn[31:27];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      squash     <= 1'b0;
      skid       <= '0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_insn  <= '0;
    end else if (redirect) begin
      pc         <= redirect_pc;
      ifid_valid <= 1'b0;
      // A request already in flight must have its response dropped.
      if (state == ISSUE || (state == WAIT && !imem_rvalid)) begin
        state  <= WAIT;
        squash <= 1'b1;
      end else begin
        state  <= ISSUE;
        squash <= 1'b0;
      end
    end else begin
      // Decode takes the instruction; a load below overrides this.
      if (ifid_valid && !stall)
        ifid_valid <= 1'b0;
      case (state)
        IDLE:  state <= ISSUE;
        ISSUE: state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (squash) begin
              squash <= 1'b0;
              state  <= ISSUE;
            end else if (ifid_valid && stall) begin
              skid  <= '{pc: pc, insn: imem_rdata};
              pc    <= pc + 32'd1;
              state <= HOLD;
            end else begin
              ifid_valid <= 1'b1;
              ifid_pc    <= pc;
              ifid_insn  <= imem_rdata;
              pc         <= pc + 32'd1;
              state      <= ISSUE;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= skid.pc;
            ifid_insn  <= skid.insn;
            state      <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
